// File: rtl/lin_resampler_axis_if.sv
// Complex IQ AXI-Stream bundle: tdata = {I, Q}, each DATA_WIDTH bits, I in the upper half.
interface lin_resampler_axis_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [2*DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, tlast, tdata, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/lin_resampler_axis.sv
// Fractional-rate linear-interpolating IQ upsampler driven by a phase accumulator.
// Define LIN_RESAMP_RND_EN for round-half-up; otherwise the result is floored.
module lin_resampler_axis #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int MU_WIDTH    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PHASE_WIDTH:0]   cfg_step,
  lin_resampler_axis_if.slave    in_axis,
  lin_resampler_axis_if.master   out_axis,
  output logic                   busy
);
  localparam int DW     = DATA_WIDTH;
  localparam int PW     = PHASE_WIDTH;
  localparam int MW     = MU_WIDTH;
  localparam int SW     = DW + MW + 1;
  localparam int STAGES = 2;
`ifdef LIN_RESAMP_RND_EN
  localparam logic signed [SW-1:0] RND = SW'(2**(MW-1));
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {S_PRIME0, S_PRIME1, S_RUN, S_LOAD} state_t;

  state_t                r_state, w_state_n;
  logic [PW-1:0]         r_phase, w_phase_n;
  logic [PW:0]           r_step, w_step_n;
  logic [1:0][DW-1:0]    r_x0, r_x1, w_x0_n, w_x1_n, w_in, w_opa, w_opb, w_y;
  logic                  r_last1, w_last1_n;
  logic                  w_en, w_tready, w_issue, w_issue_last;
  logic [MW-1:0]         w_mu;
  logic [MW:0]           w_w0, w_w1;
  logic [PW:0]           w_acc;
  logic [STAGES:1]       r_vld_pipe, r_last_pipe;

  assign w_in  = in_axis.tdata;
  assign w_en  = ~r_vld_pipe[STAGES] | out_axis.tready;
  assign w_acc = {1'b0, r_phase} + r_step;
  assign w_w1  = {1'b0, w_mu};
  assign w_w0  = {1'b1, {MW{1'b0}}} - w_w1;

  always_comb begin
    w_state_n    = r_state;
    w_phase_n    = r_phase;
    w_step_n     = r_step;
    w_x0_n       = r_x0;
    w_x1_n       = r_x1;
    w_last1_n    = r_last1;
    w_tready     = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_opa        = r_x0;
    w_opb        = r_x1;
    w_mu         = r_phase[PW-1 -: MW];
    unique case (r_state)
      S_PRIME0: begin
        // a single-sample packet issues immediately, so it needs room in the pipeline
        w_tready = w_en;
        if (in_axis.tvalid && w_en) begin
          w_x0_n    = w_in;
          w_phase_n = '0;
          w_step_n  = (cfg_step == '0) ? (PW+1)'(1) : cfg_step;
          if (in_axis.tlast) begin
            w_issue      = 1'b1;
            w_issue_last = 1'b1;
            w_opa        = w_in;
            w_mu         = '0;
          end else begin
            w_state_n = S_PRIME1;
          end
        end
      end
      S_PRIME1, S_LOAD: begin
        w_tready = 1'b1;
        if (in_axis.tvalid) begin
          w_x1_n    = w_in;
          w_last1_n = in_axis.tlast;
          w_state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (w_en) begin
          w_issue   = 1'b1;
          w_phase_n = w_acc[PW-1:0];
          if (w_acc[PW]) begin
            if (r_last1) begin
              w_issue_last = 1'b1;
              w_phase_n    = '0;
              w_state_n    = S_PRIME0;
            end else begin
              w_x0_n = r_x1;
              if (in_axis.tvalid) begin
                w_tready  = 1'b1;
                w_x1_n    = w_in;
                w_last1_n = in_axis.tlast;
              end else begin
                w_state_n = S_LOAD;
              end
            end
          end
        end
      end
      default: w_state_n = S_PRIME0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_PRIME0;
      r_phase     <= '0;
      r_step      <= (PW+1)'(1);
      r_x0        <= '0;
      r_x1        <= '0;
      r_last1     <= 1'b0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_state <= w_state_n;
      r_phase <= w_phase_n;
      r_step  <= w_step_n;
      r_x0    <= w_x0_n;
      r_x1    <= w_x1_n;
      r_last1 <= w_last1_n;
      if (w_en) begin
        r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], w_issue};
        r_last_pipe <= {r_last_pipe[STAGES-1:1], w_issue_last};
      end
    end
  end

  // lane 1 = I, lane 0 = Q; weights sum to 2^MW so the sum never overflows
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic signed [SW-1:0] w_a, w_b, w_m0, w_m1, w_sum;
    logic signed [SW-1:0] r_p0, r_p1;
    logic        [DW-1:0] r_y;

    assign w_a   = SW'($signed(w_opa[g]));
    assign w_b   = SW'($signed(w_opb[g]));
    assign w_m0  = w_a * $signed(SW'(w_w0));
    assign w_m1  = w_b * $signed(SW'(w_w1));
    assign w_sum = r_p0 + r_p1 + RND;
    assign w_y[g] = r_y;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_p0 <= '0;
        r_p1 <= '0;
        r_y  <= '0;
      end else if (w_en) begin
        r_p0 <= w_m0;
        r_p1 <= w_m1;
        r_y  <= DW'(w_sum >>> MW);
      end
    end
  end

  assign in_axis.tready  = w_tready;
  assign out_axis.tvalid = r_vld_pipe[STAGES];
  assign out_axis.tlast  = r_last_pipe[STAGES];
  assign out_axis.tdata  = w_y;
  assign busy            = (r_state != S_PRIME0) | (|r_vld_pipe);
endmodule
